kbd_cmd_sequencer: RTL and testbench
====================================

# kbd_cmd_sequencer

Host-side command sequencer for the PS/2 keyboard link. It arbitrates between two command requesters, keyboard reset and LED update, and drives the PS/2 transmitter one byte at a time. It consumes the clean received-byte stream from the FIFO reader and interprets keyboard responses (ACK, RESEND, BAT) while a command is in flight. Every received byte that is not a command response is forwarded unchanged to the scan-code decoder.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1_000_000: response timeout per wait state, in clk cycles (20 ms at 50 MHz).
- MAX_RETRY, 3: retransmissions allowed per byte on RESEND.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_valid  in  1  1-cycle strobe from the FIFO reader.
- rx_byte  in  8  received byte; valid when rx_valid is high.
- tx_ready  in  1  transmitter idle and able to accept a byte.
- tx_start  out  1  1-cycle pulse that launches a byte.
- tx_byte  out  8  byte to send; stable while tx_start is high.
- reset_req  in  1  1-cycle pulse requesting a keyboard reset.
- led_req  in  1  1-cycle pulse requesting an LED update.
- led_bits  in  3  {caps, num, scroll}; sampled with led_req.
- reset_done  out  1  1-cycle pulse: reset completed and BAT passed.
- led_done  out  1  1-cycle pulse: LED update acknowledged.
- cmd_error  out  1  1-cycle pulse: command aborted.
- scan_valid  out  1  1-cycle strobe for a forwarded byte.
- scan_byte  out  8  forwarded byte.
- busy  out  1  high in every state except IDLE.

## Operation
- Requests are latched into two pending flags, pend_rst and pend_led.
  - A led_req overwrites the latched LED value, so the newest value wins.
  - A repeated request while the same flag is already pending merges into it.
- Arbitration happens only in IDLE. pend_rst has priority over pend_led.
  - A granted flag is cleared at grant.
  - Granting reset also clears pend_led and discards its value.
- States: IDLE, SEND, WAIT_ACK, WAIT_BAT, DONE.
  - SEND issues tx_start when tx_ready is high, then goes to WAIT_ACK. The cmd_stage register selects the byte to send.
  - Reset sequence: FF -> ACK (FA) -> WAIT_BAT. In WAIT_BAT, AA goes to DONE (reset_done); FC goes to cmd_error.
  - LED sequence: ED -> ACK -> led argument {5'b0, led_bits} -> ACK -> DONE (led_done).
- In WAIT_ACK:
  - FA advances the sequence.
  - FE retransmits the current byte and increments retry_cnt. The MAX_RETRY+1-th FE causes cmd_error.
  - Any other byte is forwarded to scan_* and the state does not change.
- In WAIT_BAT, bytes other than AA and FC are forwarded.
- In IDLE, SEND and DONE, every byte is forwarded.
- Timeout counter:
  - Cleared on entry to each wait state.
  - Reaching TIMEOUT_CYCLES-1 causes cmd_error and a return to IDLE.
  - Never runs in SEND. The transmitter owns that timeout.
- retry_cnt clears at each new byte.
- DONE lasts one cycle, then the block returns to IDLE.

## Timing
- Reset values:
  - tx_start = 0, tx_byte = 00, scan_valid = 0, scan_byte = 00.
  - reset_done, led_done, cmd_error = 0; busy = 0.
  - Pending flags cleared; state IDLE; counters 0.
- Forwarding latency: scan_valid is asserted exactly 1 cycle after rx_valid. A byte that is consumed as a response never produces scan_valid.
- A grant in IDLE enters SEND on the next cycle. tx_start comes at the earliest 1 cycle after that, and only when tx_ready is high.
- Done or error pulses are registered and appear 1 cycle after the deciding rx_valid or the timeout.
- A request pulse that coincides with the grant of the same flag is not lost; it re-sets the flag.
- If rx_valid and timeout expiry occur in the same cycle, the byte is evaluated and the timeout is ignored.
- Asserting rst mid-command aborts immediately. No done or error pulse is produced, and pending requests are lost.

## Configuration
- KBD_CMD_RETRY_EN defined: FE triggers retransmission up to MAX_RETRY times, as above.
- KBD_CMD_RETRY_EN undefined: no retry counter is built. The first FE in WAIT_ACK causes cmd_error.

## Structure
- The shared package kbd_pkg holds:
  - Byte constants: CMD_RESET = FF, CMD_SET_LED = ED, RSP_ACK = FA, RSP_RESEND = FE, RSP_BAT_OK = AA, RSP_BAT_FAIL = FC.
  - The sequencer state enum.
- One sub-module, kbd_resp_timer, holds the loadable timeout counter with its clear input and expiry flag.

## Test plan
- reset_req, kbd replies FA then AA -> tx_byte FF once; reset_done pulses 1 cycle after AA; no scan_valid for FA or AA.
- led_req with led_bits = 3'b101, kbd replies FA, FA -> tx_byte sequence ED, 05; led_done pulse; busy low afterwards.
- reset_req and led_req in the same cycle -> only the FF sequence runs; pend_led is discarded; no ED is ever sent.
- With the macro on, ED answered FE, FE, FA -> ED sent 3 times, then 05. Four FEs -> cmd_error with MAX_RETRY = 3. With the macro off, one FE -> cmd_error.
- In WAIT_ACK, byte 1C arrives, then no further response -> scan_byte = 1C one cycle later; cmd_error after TIMEOUT_CYCLES; state IDLE.
- rst asserted during WAIT_BAT -> all outputs return to reset values asynchronously; no done pulse follows.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared byte constants and sequencer state encoding for the PS/2 keyboard command path.
package kbd_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_DONE
  } seq_state_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kbd_resp_timer.sv
// Keyboard response timeout: down-counter loaded on clear, expiry at terminal count zero.
module kbd_resp_timer
  import kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= LOAD_VAL;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = run && (cnt == '0);

endmodule

// File: rtl/kbd_cmd_sequencer.sv
// Host command sequencer for the PS/2 keyboard: arbitrates reset/LED commands and filters responses.
// Build option: KBD_CMD_RETRY_EN enables retransmission on RESEND (otherwise first RESEND aborts).
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no command in flight; arbitrates pending requests
// ST_SEND     | waiting for tx_ready to launch the byte chosen by cmd_stage
// ST_WAIT_ACK | byte sent; waiting for ACK / RESEND, timeout running
// ST_WAIT_BAT | reset acknowledged; waiting for BAT result, timeout running
// ST_DONE     | one-cycle completion state
module kbd_cmd_sequencer
  import kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       reset_req,
  input  logic       led_req,
  input  logic [2:0] led_bits,
  output logic       reset_done,
  output logic       led_done,
  output logic       cmd_error,
  output logic       scan_valid,
  output logic [7:0] scan_byte,
  output logic       busy
);

  seq_state_t state, state_nxt;

  logic       cmd_led, cmd_led_nxt;
  logic       cmd_stage, cmd_stage_nxt;
  logic [2:0] cur_led_bits;
  logic       pend_rst, pend_led;
  logic [2:0] pend_led_bits;

  logic       grant_rst, grant_led;
  logic       consume;
  logic       ev_rst_done, ev_led_done, ev_error;
  logic       retry_ok;
  logic       tmo_clear, tmo_run, tmo_expired;
  logic       tx_start_nxt, scan_valid_nxt;
  logic [7:0] cur_byte;

  assign cur_byte = !cmd_led  ? CMD_RESET :
                    cmd_stage ? {5'b0, cur_led_bits} : CMD_SET_LED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_led      <= 1'b0;
      cmd_stage    <= 1'b0;
      cur_led_bits <= '0;
    end else begin
      state     <= state_nxt;
      cmd_led   <= cmd_led_nxt;
      cmd_stage <= cmd_stage_nxt;
      if (grant_led) cur_led_bits <= pend_led_bits;
    end
  end

  always_comb begin
    state_nxt     = state;
    cmd_led_nxt   = cmd_led;
    cmd_stage_nxt = cmd_stage;
    grant_rst     = 1'b0;
    grant_led     = 1'b0;
    consume       = 1'b0;
    ev_rst_done   = 1'b0;
    ev_led_done   = 1'b0;
    ev_error      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pend_rst) begin
          grant_rst     = 1'b1;
          cmd_led_nxt   = 1'b0;
          cmd_stage_nxt = 1'b0;
          state_nxt     = ST_SEND;
        end else if (pend_led) begin
          grant_led     = 1'b1;
          cmd_led_nxt   = 1'b1;
          cmd_stage_nxt = 1'b0;
          state_nxt     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // A byte arriving together with expiry wins over the timeout.
        if (rx_valid) begin
          if (rx_byte == RSP_ACK) begin
            consume = 1'b1;
            if (!cmd_led) begin
              state_nxt = ST_WAIT_BAT;
            end else if (!cmd_stage) begin
              cmd_stage_nxt = 1'b1;
              state_nxt     = ST_SEND;
            end else begin
              ev_led_done = 1'b1;
              state_nxt   = ST_DONE;
            end
          end else if (rx_byte == RSP_RESEND) begin
            consume = 1'b1;
            if (retry_ok) begin
              state_nxt = ST_SEND;
            end else begin
              ev_error  = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
        end else if (tmo_expired) begin
          ev_error  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_BAT: begin
        if (rx_valid) begin
          if (rx_byte == RSP_BAT_OK) begin
            consume     = 1'b1;
            ev_rst_done = 1'b1;
            state_nxt   = ST_DONE;
          end else if (rx_byte == RSP_BAT_FAIL) begin
            consume   = 1'b1;
            ev_error  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (tmo_expired) begin
          ev_error  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_start_nxt   = (state == ST_SEND) && tx_ready;
    scan_valid_nxt = rx_valid && !consume;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start   <= 1'b0;
      tx_byte    <= '0;
      scan_valid <= 1'b0;
      scan_byte  <= '0;
      reset_done <= 1'b0;
      led_done   <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      tx_start   <= tx_start_nxt;
      scan_valid <= scan_valid_nxt;
      reset_done <= ev_rst_done;
      led_done   <= ev_led_done;
      cmd_error  <= ev_error;
      if (tx_start_nxt)   tx_byte   <= cur_byte;
      if (scan_valid_nxt) scan_byte <= rx_byte;
    end
  end

  // A request arriving in the grant cycle re-arms its flag; a reset grant drops any LED request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_rst      <= 1'b0;
      pend_led      <= 1'b0;
      pend_led_bits <= '0;
    end else begin
      pend_rst <= reset_req | (pend_rst & ~grant_rst);
      pend_led <= led_req | (pend_led & ~grant_led & ~grant_rst);
      if (led_req)        pend_led_bits <= led_bits;
      else if (grant_rst) pend_led_bits <= '0;
    end
  end

`ifdef KBD_CMD_RETRY_EN
  localparam int unsigned RETRY_W = cnt_width(MAX_RETRY + 1);

  logic [RETRY_W-1:0] retry_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= '0;
    end else if ((state == ST_IDLE) ||
                 ((state == ST_WAIT_ACK) && rx_valid && (rx_byte == RSP_ACK))) begin
      retry_cnt <= '0;
    end else if ((state == ST_WAIT_ACK) && rx_valid && (rx_byte == RSP_RESEND) && retry_ok) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end

  assign retry_ok = (retry_cnt != RETRY_W'(MAX_RETRY));
`else
  assign retry_ok = 1'b0;
`endif

  assign tmo_run   = (state == ST_WAIT_ACK) || (state == ST_WAIT_BAT);
  assign tmo_clear = (state_nxt != state);

  kbd_resp_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_resp_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .run    (tmo_run),
    .expired(tmo_expired)
  );

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_kbd_cmd_sequencer.sv
// Self-checking bench for kbd_cmd_sequencer: vector table, directed corner cases, randomized commands.
module tb_kbd_cmd_sequencer;

  localparam int unsigned TMO = 40;
  localparam int unsigned MR  = 3;
`ifdef KBD_CMD_RETRY_EN
  localparam int RETRY_ALLOWED = MR;
`else
  localparam int RETRY_ALLOWED = 0;
`endif

  logic       clk, rst;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       reset_req, led_req;
  logic [2:0] led_bits;
  logic       reset_done, led_done, cmd_error;
  logic       scan_valid;
  logic [7:0] scan_byte;
  logic       busy;

  int checks = 0;
  int failures = 0;

  kbd_cmd_sequencer #(.TIMEOUT_CYCLES(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_byte(tx_byte),
    .reset_req(reset_req), .led_req(led_req), .led_bits(led_bits),
    .reset_done(reset_done), .led_done(led_done), .cmd_error(cmd_error),
    .scan_valid(scan_valid), .scan_byte(scan_byte), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rxv;
    logic [7:0] rxb;
    logic       sv;
    logic [7:0] sb;
  } fwd_vec_t;

  fwd_vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit q_same(input logic [7:0] a[$], input logic [7:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic pulse_req(input logic r, input logic l, input logic [2:0] bits);
    reset_req = r; led_req = l; led_bits = bits;
    @(negedge clk);
    reset_req = 1'b0; led_req = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input logic [7:0] exp, input string nm);
    int n;
    n = 0;
    while (!tx_start && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_tx"}, {23'b0, tx_start, tx_byte}, {23'b0, 1'b1, exp});
  endtask

  task automatic count_tx(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx_start) n++;
    end
  endtask

  // Builds the expected transaction from the protocol rules, replays it as the keyboard, compares.
  task automatic run_random_txn();
    logic [7:0] sendb[$];
    logic [8:0] script[$];
    logic [7:0] exp_tx[$], exp_fwd[$], obs_tx[$], obs_fwd[$];
    int idx, tries, outcome, sp, cyc, last_drv, n_rd, n_ld, n_err;
    bit is_led;
    logic [2:0] bits;
    logic [7:0] j;

    is_led = 1'($urandom_range(0, 1));
    bits   = 3'($urandom_range(0, 7));
    if (is_led) begin
      sendb.push_back(8'hED);
      sendb.push_back({5'b0, bits});
    end else begin
      sendb.push_back(8'hFF);
    end
    idx = 0; tries = 0; outcome = -1;
    while (outcome < 0) begin
      exp_tx.push_back(sendb[idx]);
      script.push_back(9'h100);
      repeat ($urandom_range(0, 2)) begin
        j = 8'($urandom_range(0, 127));
        script.push_back({1'b0, j});
        exp_fwd.push_back(j);
      end
      if ($urandom_range(0, 3) == 0) begin
        script.push_back({1'b0, 8'hFE});
        if (tries < RETRY_ALLOWED) tries++;
        else outcome = 2;
      end else begin
        script.push_back({1'b0, 8'hFA});
        tries = 0;
        idx++;
        if (idx == sendb.size()) begin
          if (is_led) begin
            outcome = 1;
          end else begin
            repeat ($urandom_range(0, 2)) begin
              j = 8'($urandom_range(0, 127));
              script.push_back({1'b0, j});
              exp_fwd.push_back(j);
            end
            if ($urandom_range(0, 3) == 0) begin
              script.push_back({1'b0, 8'hFC});
              outcome = 2;
            end else begin
              script.push_back({1'b0, 8'hAA});
              outcome = 0;
            end
          end
        end
      end
    end

    pulse_req(!is_led, is_led, bits);
    sp = 0; cyc = 0; last_drv = 0; n_rd = 0; n_ld = 0; n_err = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (tx_start)   obs_tx.push_back(tx_byte);
      if (scan_valid) obs_fwd.push_back(scan_byte);
      if (reset_done) n_rd++;
      if (led_done)   n_ld++;
      if (cmd_error)  n_err++;
      rx_valid = 1'b0;
      tx_ready = ($urandom_range(0, 3) != 0);
      if (sp < script.size() && script[sp][8] && tx_start) sp++;
      if (sp < script.size() && !script[sp][8] && $urandom_range(0, 2) != 0) begin
        rx_valid = 1'b1;
        rx_byte  = script[sp][7:0];
        sp++;
        last_drv = cyc;
      end
      if (sp == script.size() && !busy && cyc >= last_drv + 2) break;
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    chk("rnd_budget", {31'b0, cyc < 2000}, 32'd1);
    chk("rnd_tx_seq", {8'(obs_tx.size()), 23'b0, q_same(obs_tx, exp_tx)},
        {8'(exp_tx.size()), 23'b0, 1'b1});
    chk("rnd_fwd_seq", {8'(obs_fwd.size()), 23'b0, q_same(obs_fwd, exp_fwd)},
        {8'(exp_fwd.size()), 23'b0, 1'b1});
    chk("rnd_pulses", {8'(n_rd), 8'(n_ld), 8'(n_err)},
        {8'(outcome == 0), 8'(outcome == 1), 8'(outcome == 2)});
    chk("rnd_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; rx_valid = 1'b0; rx_byte = '0; tx_ready = 1'b1;
    reset_req = 1'b0; led_req = 1'b0; led_bits = '0;

    vecs[0] = '{1'b1, 8'h1C, 1'b1, 8'h1C};
    vecs[1] = '{1'b0, 8'h55, 1'b0, 8'h1C};
    vecs[2] = '{1'b1, 8'hFA, 1'b1, 8'hFA};
    vecs[3] = '{1'b1, 8'hFE, 1'b1, 8'hFE};
    vecs[4] = '{1'b1, 8'hAA, 1'b1, 8'hAA};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 8'hAA};
    vecs[6] = '{1'b1, 8'hFC, 1'b1, 8'hFC};
    vecs[7] = '{1'b1, 8'h00, 1'b1, 8'h00};

    repeat (2) @(negedge clk);
    chk("reset_outputs", {10'b0, tx_start, tx_byte, scan_valid, scan_byte,
                          reset_done, led_done, cmd_error, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Forwarding in IDLE: every byte passes through, one cycle later.
    for (int i = 0; i < 8; i++) begin
      rx_valid = vecs[i].rxv;
      rx_byte  = vecs[i].rxb;
      @(negedge clk);
      chk("fwd_vec", {21'b0, busy, tx_start, scan_valid, scan_byte},
          {21'b0, 1'b0, 1'b0, vecs[i].sv, vecs[i].sb});
    end
    rx_valid = 1'b0;
    @(negedge clk);

    // Reset command with exact latencies.
    pulse_req(1'b1, 1'b0, 3'b000);
    chk("rst_pending_idle", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("rst_in_send", {30'b0, busy, tx_start}, {30'b0, 2'b10});
    @(negedge clk);
    chk("rst_tx_ff", {23'b0, tx_start, tx_byte}, {23'b0, 1'b1, 8'hFF});
    send_rx(8'hFA);
    chk("rst_ack_consumed", {29'b0, scan_valid, tx_start, busy}, {29'b0, 3'b001});
    send_rx(8'hAA);
    chk("rst_done_pulse", {29'b0, reset_done, scan_valid, busy}, {29'b0, 3'b101});
    @(negedge clk);
    chk("rst_after", {30'b0, reset_done, busy}, 32'd0);

    // LED update 101.
    pulse_req(1'b0, 1'b1, 3'b101);
    wait_tx(8'hED, "led_cmd");
    send_rx(8'hFA);
    chk("led_ack1", {31'b0, scan_valid}, 32'd0);
    wait_tx(8'h05, "led_arg");
    send_rx(8'hFA);
    chk("led_done_pulse", {30'b0, led_done, scan_valid}, {30'b0, 2'b10});
    @(negedge clk);
    chk("led_after", {30'b0, led_done, busy}, 32'd0);

    // Simultaneous requests: reset wins, LED request is discarded.
    pulse_req(1'b1, 1'b1, 3'b010);
    wait_tx(8'hFF, "both");
    send_rx(8'hFA);
    send_rx(8'hAA);
    chk("both_rst_done", {31'b0, reset_done}, 32'd1);
    count_tx(30, n);
    chk("both_no_led", n, 32'd0);
    chk("both_idle", {31'b0, busy}, 32'd0);

`ifdef KBD_CMD_RETRY_EN
    pulse_req(1'b0, 1'b1, 3'b101);
    wait_tx(8'hED, "retry0");
    send_rx(8'hFE);
    chk("retry_fe_consumed", {30'b0, scan_valid, cmd_error}, 32'd0);
    wait_tx(8'hED, "retry1");
    send_rx(8'hFE);
    wait_tx(8'hED, "retry2");
    send_rx(8'hFA);
    wait_tx(8'h05, "retry_arg");
    send_rx(8'hFA);
    chk("retry_led_done", {31'b0, led_done}, 32'd1);
    @(negedge clk);

    pulse_req(1'b1, 1'b0, 3'b000);
    for (int k = 0; k < 4; k++) begin
      wait_tx(8'hFF, "retry_exh");
      send_rx(8'hFE);
      chk("retry_exh_err", {30'b0, cmd_error, busy}, (k == 3) ? 32'd2 : 32'd1);
    end
    @(negedge clk);
`else
    pulse_req(1'b0, 1'b1, 3'b101);
    wait_tx(8'hED, "noretry");
    send_rx(8'hFE);
    chk("noretry_err", {29'b0, cmd_error, busy, scan_valid}, {29'b0, 3'b100});
    count_tx(10, n);
    chk("noretry_no_resend", n, 32'd0);
`endif
    chk("err_pulse_gone", {31'b0, cmd_error}, 32'd0);

    // Timeout in WAIT_ACK after a forwarded non-response byte.
    pulse_req(1'b1, 1'b0, 3'b000);
    wait_tx(8'hFF, "tmo");
    send_rx(8'h1C);
    chk("tmo_fwd", {22'b0, busy, scan_valid, scan_byte}, {22'b0, 1'b1, 1'b1, 8'h1C});
    n = 0;
    while (!cmd_error && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, TMO - 1);
    chk("tmo_idle", {30'b0, cmd_error, busy}, {30'b0, 2'b10});
    @(negedge clk);

    for (int t = 0; t < 40; t++) run_random_txn();
    repeat (2) @(negedge clk);

    // Asynchronous reset in WAIT_BAT with an LED request pending.
    pulse_req(1'b1, 1'b0, 3'b000);
    wait_tx(8'hFF, "ar");
    send_rx(8'hFA);
    send_rx(8'h1C);
    chk("ar_pre", {14'b0, busy, tx_byte, scan_valid, scan_byte},
        {14'b0, 1'b1, 8'hFF, 1'b1, 8'h1C});
    pulse_req(1'b0, 1'b1, 3'b111);
    #1 rst = 1'b1;
    #1 chk("ar_async", {10'b0, tx_start, tx_byte, scan_valid, scan_byte,
                        reset_done, led_done, cmd_error, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_rx(8'hAA);
    chk("ar_no_done", {20'b0, reset_done, busy, scan_valid, scan_byte},
        {20'b0, 1'b0, 1'b0, 1'b1, 8'hAA});
    count_tx(20, n);
    chk("ar_pend_lost", n, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
